// File: rtl/demux4_b4_seq_if.sv
// demux4_b4_seq_if: bus bundle for the registered 1-to-4 demultiplexer.
//   din/valid : data word and its write enable
//   ctrl      : manual channel select (0=A .. 3=D)
//   auto      : 1 selects the internal dwell-timed rotating channel
//   A..D      : held channel registers
//   ch        : registered current channel
//   wr        : registered one-hot write strobe
//   frame     : one-cycle pulse when auto rotation wraps 3->0
// master drives the inputs (producer side), slave is the demux itself.
interface demux4_b4_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             valid;
  logic [1:0]       ctrl;
  logic             auto;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [1:0]       ch;
  logic [3:0]       wr;
  logic             frame;

  modport master (
    output din, valid, ctrl, auto,
    input  A, B, C, D, ch, wr, frame
  );

  modport slave (
    input  din, valid, ctrl, auto,
    output A, B, C, D, ch, wr, frame
  );
endinterface

// File: rtl/demux4_b4_seq.sv
// demux4_b4_seq: registered 1-to-4 demultiplexer / channel distributor.
// One WIDTH-bit word is steered into one of four held registers (A..D).
// The target channel is either ctrl (manual) or an internal channel that
// rotates every DWELL cycles (auto).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : demux4_b4_seq_if.slave (din, valid, ctrl, auto, A..D, ch, wr, frame)

// One channel register: loads din when its write enable is set.
module demux4_b4_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= din;
  end
endmodule

module demux4_b4_seq #(
  parameter int WIDTH = 4,
  parameter int DWELL = 50
) (
  input logic             clk,
  input logic             rst_n,
  demux4_b4_seq_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int CW        = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0]                      cnt;
  logic [1:0]                         ch_q;
  logic [NUM_LANES-1:0]               wr_q;
  logic                               frame_q;
  logic [NUM_LANES-1:0][WIDTH-1:0]    lane_q;
  logic [1:0]                         sel;
  logic                               last;
  logic [NUM_LANES-1:0]               onehot;

  // Write target uses the pre-advance channel, so a write landing on the
  // advance edge still goes to the old channel.
  assign sel    = bus.auto ? ch_q : bus.ctrl;
  assign last   = (cnt == CW'(DWELL - 1));
  assign onehot = NUM_LANES'(1) << sel;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux4_b4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.valid && (sel == 2'(i))),
      .din   (bus.din[WIDTH-1:0]),
      .q     (lane_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      ch_q    <= '0;
      wr_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      wr_q <= bus.valid ? onehot : '0;
      if (!bus.auto) begin
        // Manual: ch tracks ctrl one cycle late; the dwell restarts fresh
        // on the next entry into auto mode.
        ch_q    <= bus.ctrl;
        cnt     <= '0;
        frame_q <= 1'b0;
      end else if (last) begin
        cnt     <= '0;
        ch_q    <= ch_q + 2'd1;
        frame_q <= (ch_q == 2'd3);
      end else begin
        cnt     <= cnt + 1'b1;
        frame_q <= 1'b0;
      end
    end
  end

  assign bus.A     = lane_q[0];
  assign bus.B     = lane_q[1];
  assign bus.C     = lane_q[2];
  assign bus.D     = lane_q[3];
  assign bus.ch    = ch_q;
  assign bus.wr    = wr_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_demux4_b4_seq.sv
module tb_demux4_b4_seq;
  localparam int WIDTH = 4;
  localparam int DWELL = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux4_b4_seq_if #(.WIDTH(WIDTH)) bus ();
  demux4_b4_seq #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] a, b, c, d;
    logic [1:0] ch;
    logic [3:0] wr;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a channel "stays" for DWELL auto cycles, tracked as
  // cycles remaining on the current channel.
  int m_reg[4];
  int m_ch, m_left, m_wr, m_frame;

  function automatic void model_step(bit r, int din, bit valid, int ctrl, bit au);
    int s;
    if (!r) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_ch = 0; m_wr = 0; m_frame = 0; m_left = DWELL;
      return;
    end
    s = au ? m_ch : ctrl;
    if (valid) begin
      m_reg[s] = din;
      m_wr     = 1 << s;
    end else m_wr = 0;
    if (!au) begin
      m_ch = ctrl; m_left = DWELL; m_frame = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_frame = (m_ch == 3);
        m_ch    = (m_ch + 1) % 4;
        m_left  = DWELL;
      end else m_frame = 0;
    end
  endfunction

  task automatic cyc(bit r, int din, bit valid, int ctrl, bit au);
    exp_t e;
    @(negedge clk);
    rst_n     = r;
    bus.din   = 4'(din);
    bus.valid = valid;
    bus.ctrl  = 2'(ctrl);
    bus.auto  = au;
    model_step(r, din, valid, ctrl, au);
    e.a = 4'(m_reg[0]); e.b = 4'(m_reg[1]); e.c = 4'(m_reg[2]); e.d = 4'(m_reg[3]);
    e.ch = 2'(m_ch); e.wr = 4'(m_wr); e.frame = m_frame[0];
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge that follows a stimulus produces one output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("A", bus.A, e.a);
        chk("B", bus.B, e.b);
        chk("C", bus.C, e.c);
        chk("D", bus.D, e.d);
        chk("ch", {2'b0, bus.ch}, {2'b0, e.ch});
        chk("wr", bus.wr, e.wr);
        chk("frame", {3'b0, bus.frame}, {3'b0, e.frame});
      end
    end
  end

  initial begin
    rst_n = 1'b0; bus.din = '0; bus.valid = 1'b0; bus.ctrl = '0; bus.auto = 1'b0;
    // Reset held with a pending write
    repeat (2) cyc(0, 'hF, 1, 0, 0);
    cyc(1, 'hF, 0, 0, 0);
    // Manual distribution then hold
    for (int i = 0; i < 4; i++) cyc(1, 1 << i, 1, i, 0);
    repeat (3) cyc(1, 'h5, 0, 0, 0);
    // Full auto rotation from ch=0
    repeat (4 * DWELL + 5) cyc(1, 0, 0, 0, 1);
    // Writes exactly on advance edges
    repeat (4 * DWELL) cyc(1, $urandom_range(15), (m_left == 1), 0, 1);
    // Mode switch mid-dwell, then back to auto
    repeat (10) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 3, 0);
    repeat (DWELL + 3) cyc(1, 0, 0, 0, 1);
    // Reset mid-operation, rotation restarts
    repeat (30) cyc(1, 8, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    repeat (DWELL + 3) cyc(1, 0, 0, 0, 1);
    // Random traffic with occasional mode flips and resets
    begin
      bit au = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(99) < 2) au = ~au;
        cyc(($urandom_range(299) != 0), $urandom_range(15), $urandom_range(1),
            $urandom_range(3), au);
      end
    end
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain outstanding=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
